// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// A winner may lock the register for a burst of up to LOCK_MAX transfers.
module reg_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4,
  localparam int IDW     = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [IDW-1:0]         grant_id,
  output logic                   locked
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   owner_reg, owner_next;
  logic [IDW-1:0]   grant_id_reg, grant_id_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_valid_reg, q_valid_next;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [N_REQ-1:0] ready_vec;
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             xfer;
  logic [IDW-1:0]   xfer_idx;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester at or after ptr, wrapping at N_REQ (not at 2**IDW).
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_valid[IDW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
      assign ready_vec[gi] = (state_reg == IDLE) ? (win_found && win_idx == IDW'(gi))
                                                 : (owner_reg == IDW'(gi) && req_valid[gi]);
    end
  endgenerate

  // Gated by reset so no handshake can complete while the register is held clear.
  assign req_ready = reset ? ready_vec : '0;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_idx  = (state_reg == IDLE) ? win_idx : owner_reg;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    q_next        = q_reg;
    grant_id_next = grant_id_reg;
    q_valid_next  = xfer;
    if (xfer) begin
      q_next        = data_arr[xfer_idx];
      grant_id_next = xfer_idx;
    end
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          if (req_lock[xfer_idx] && LOCK_MAX > 1) begin
            state_next = LOCKED;
            owner_next = xfer_idx;
            cnt_next   = CW'(1);
          end else begin
            ptr_next = wrap_inc(xfer_idx);
          end
        end
      end
      LOCKED: begin
        if (!req_lock[owner_reg]) begin
          state_next = IDLE;
          ptr_next   = wrap_inc(owner_reg);
          cnt_next   = '0;
        end else if (xfer) begin
          if (int'(cnt_reg) + 1 == LOCK_MAX) begin
            state_next = IDLE;
            ptr_next   = wrap_inc(owner_reg);
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      cnt_reg      <= '0;
      q_reg        <= '0;
      q_valid_reg  <= 1'b0;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      q_reg        <= q_next;
      q_valid_reg  <= q_valid_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign q        = q_reg;
  assign q_valid  = q_valid_reg;
  assign grant_id = grant_id_reg;
  assign locked   = (state_reg == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios then compliant random masters,
// all checked against an index-arithmetic reference model.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LM = 4;
  localparam int IW = 2;

  logic           clk       = 1'b0;
  logic           reset     = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_lock  = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [IW-1:0]  grant_id;
  logic           locked;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: rotation pointer, burst owner and writes in the current burst.
  int           m_ptr;
  int           m_owner;
  int           m_burst;
  bit           m_locked;
  bit           m_qv;
  logic [W-1:0] m_q;
  int           m_gid;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .LOCK_MAX(LM)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q         (q),
    .q_valid   (q_valid),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_burst = 0; m_locked = 0; m_qv = 0; m_q = '0; m_gid = 0;
  endtask

  function automatic int pick();
    int i;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    if (w >= 0) begin
      m_q   = req_data[w*W +: W];
      m_gid = w;
      m_qv  = 1;
      $display("xfer: req%0d data=%02h lock=%0d", w, m_q, req_lock[w]);
    end else begin
      m_qv = 0;
    end
    if (!m_locked) begin
      if (w >= 0) begin
        if (req_lock[w] && LM > 1) begin
          m_locked = 1; m_owner = w; m_burst = 1;
        end else begin
          m_ptr = (w + 1) % N;
        end
      end
    end else if (!req_lock[m_owner]) begin
      m_locked = 0;
      m_ptr    = (m_owner + 1) % N;
    end else if (w >= 0) begin
      m_burst++;
      if (m_burst == LM) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input logic [W-1:0] d);
    req_valid[i]       = v;
    req_lock[i]        = l;
    req_data[i*W +: W] = d;
  endtask

  // Called just after a falling edge with inputs driven; returns the granted index.
  task automatic cycle(output int w);
    logic [N-1:0] exp_rdy;
    #1;
    w       = pick();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("q",         32'(q),         32'(m_q));
    check_val("q_valid",   32'(q_valid),   32'(m_qv));
    check_val("grant_id",  32'(grant_id),  32'(m_gid));
    check_val("locked",    32'(locked),    32'(m_locked));
    @(posedge clk);
    model_edge(w);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int wr1;
    int cnt_lk;
    model_reset();

    // Reset held: requests present but nothing may be accepted.
    req_valid = '1;
    #4;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_q",     32'(q),         32'd0);
    #4;
    check_val("rst_ready2",  32'(req_ready), 32'd0);
    check_val("rst_q_valid", 32'(q_valid),   32'd0);
    check_val("rst_locked",  32'(locked),    32'd0);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;

    // All four valid, no lock: strict rotation 0,1,2,3.
    for (int k = 0; k < N; k++) set_req(k, 1, 0, W'(16 + k));
    for (int k = 0; k < N; k++) begin
      cycle(w);
      check_val("t2_gid",     32'(grant_id), 32'(k));
      check_val("t2_q",       32'(q),        32'(16 + k));
      check_val("t2_q_valid", 32'(q_valid),  32'd1);
    end
    for (int k = 0; k < N; k++) set_req(k, 0, 0, '0);

    // ptr=2 after a grant to req1; req3 beats req0.
    set_req(1, 1, 0, 8'h21);
    cycle(w);
    set_req(1, 0, 0, '0);
    set_req(0, 1, 0, 8'h30);
    set_req(3, 1, 0, 8'h33);
    cycle(w);
    check_val("t3_first", 32'(grant_id), 32'd3);
    set_req(3, 0, 0, '0);
    cycle(w);
    check_val("t3_second", 32'(grant_id), 32'd0);
    set_req(0, 0, 0, '0);

    // req1 locks for six writes, req2 waits: forced rotation after LOCK_MAX.
    wr1 = 0; cnt_lk = 0;
    set_req(1, 1, 1, 8'h40);
    set_req(2, 1, 0, 8'h52);
    for (int c = 0; c < 5; c++) begin
      cycle(w);
      if (locked) cnt_lk++;
      if (w == 1) begin
        wr1++;
        set_req(1, 1, 1, W'(8'h40 + wr1));
      end
    end
    check_val("t4_rot_gid",  32'(grant_id), 32'd2);
    check_val("t4_lock_cyc", 32'(cnt_lk),   32'd3);
    check_val("t4_writes",   32'(wr1),      32'd4);
    set_req(2, 0, 0, '0);
    for (int c = 0; c < 6 && wr1 < 6; c++) begin
      cycle(w);
      if (w == 1) begin
        wr1++;
        set_req(1, 1, 1, W'(8'h40 + wr1));
      end
    end
    check_val("t4_total", 32'(wr1), 32'd6);
    set_req(1, 0, 1, '0);
    cycle(w);
    cycle(w);
    check_val("t4_stall_locked", 32'(locked), 32'd1);
    set_req(1, 0, 0, '0);
    cycle(w);
    check_val("t4_unlock", 32'(locked), 32'd0);

    // req0 ends its burst by dropping lock on a final write.
    set_req(0, 1, 1, 8'h60);
    cycle(w);
    set_req(0, 1, 1, 8'h61);
    cycle(w);
    set_req(0, 1, 0, 8'hA5);
    set_req(1, 1, 0, 8'h71);
    cycle(w);
    check_val("t5_q",      32'(q),      32'hA5);
    check_val("t5_locked", 32'(locked), 32'd0);
    set_req(0, 0, 0, '0);
    cycle(w);
    check_val("t5_next", 32'(grant_id), 32'd1);
    set_req(1, 0, 0, '0);

    // Async reset in the middle of a burst (two writes in).
    set_req(2, 1, 1, 8'h80);
    cycle(w);
    cycle(w);
    check_val("t6_pre_locked", 32'(locked), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("t6_locked",  32'(locked),    32'd0);
    check_val("t6_q",       32'(q),         32'd0);
    check_val("t6_q_valid", 32'(q_valid),   32'd0);
    check_val("t6_ready",   32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1, 0, W'(8'h90 + k));
    cycle(w);
    check_val("t6_restart", 32'(grant_id), 32'd0);
    for (int k = 0; k < N; k++) set_req(k, 0, 0, '0);
    cycle(w);

    // Random compliant masters: valid held until transferred.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1, 1'($urandom_range(0, 1)), W'($urandom));
      end
      cycle(w);
      if (w >= 0) begin
        if ($urandom_range(0, 1) == 0) set_req(w, 0, 1'($urandom_range(0, 1)), '0);
        else                           set_req(w, 1, 1'($urandom_range(0, 1)), W'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
